updown_sweep_ctrl: RTL

Upstream command sequencer for the 4-bit up/down counter. It drives the counter's `m`, `e`, `ld` and `din` inputs so the count sweeps between a programmable low and high bound at a prescaled rate. It reads the counter's `out` back on `cnt` and stops after a programmable number of sweeps, or runs continuously. The counter never wraps under this controller, so its `t` output stays 0 in normal operation.

---
 rtl/updown_sweep_ctrl.sv | 223 ++++++++++++++++++++++
 1 files changed

// File: rtl/updown_sweep_ctrl.sv
// Sweep sequencer for a 4-bit up/down counter: ramps cnt between lo and hi at a prescaled rate.
// Latency: m/e/ld/din combinational from state, tick and cnt; done/err registered, one cycle after the deciding edge.
// Flow: start is a level sampled in IDLE only, stop aborts at the next edge; UPDOWN_SWEEP_HOLD_EN adds an endpoint hold tick.
module updown_sweep_ctrl #(
    parameter int DIV_W = 8
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             start,
    input  logic             stop,
    input  logic [3:0]       lo,
    input  logic [3:0]       hi,
    input  logic [DIV_W-1:0] div,
    input  logic [3:0]       cycles,
    input  logic [3:0]       cnt,
    output logic             m,
    output logic             e,
    output logic             ld,
    output logic [3:0]       din,
    output logic             busy,
    output logic             done,
    output logic             err
);

`ifdef UPDOWN_SWEEP_HOLD_EN
    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LOAD    = 3'd1,
        S_UP      = 3'd2,
        S_DOWN    = 3'd3,
        S_HOLD_HI = 3'd4,
        S_HOLD_LO = 3'd5
    } state_t;
`else
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_UP   = 2'd2,
        S_DOWN = 2'd3
    } state_t;
`endif

    state_t           state_q;
    state_t           state_d;

    logic [3:0]       lo_q;
    logic [3:0]       hi_q;
    logic [DIV_W-1:0] div_q;
    logic [3:0]       cyc_q;
    logic [DIV_W-1:0] presc_q;
    logic [3:0]       sweep_q;
    logic [3:0]       sweep_nxt;
    logic             done_q;
    logic             err_q;

    logic             counting;
    logic             tick;
    logic             capture;
    logic             sweep_inc;
    logic             done_d;
    logic             err_d;

    // The prescaler only runs while the count is sweeping or holding.
`ifdef UPDOWN_SWEEP_HOLD_EN
    assign counting = (state_q == S_UP) || (state_q == S_DOWN) ||
                      (state_q == S_HOLD_HI) || (state_q == S_HOLD_LO);
`else
    assign counting = (state_q == S_UP) || (state_q == S_DOWN);
`endif

    assign tick      = counting && (presc_q == div_q);
    assign sweep_nxt = sweep_q + 4'd1;

    assign busy = (state_q != S_IDLE);
    assign done = done_q;
    assign err  = err_q;

    always_comb begin
        state_d   = state_q;
        m         = 1'b1;
        e         = 1'b0;
        ld        = 1'b0;
        din       = lo_q;
        capture   = 1'b0;
        sweep_inc = 1'b0;
        done_d    = 1'b0;
        err_d     = 1'b0;

        case (state_q)
            S_IDLE: begin
                // stop beats start: nothing is captured and nothing is flagged
                if (start && !stop) begin
                    if (lo < hi) begin
                        capture = 1'b1;
                        state_d = S_LOAD;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end

            S_LOAD: begin
                if (stop) begin
                    state_d = S_IDLE;
                end else begin
                    ld      = 1'b1;
                    state_d = S_UP;
                end
            end

            S_UP: begin
                m = 1'b1;
                if (stop) begin
                    state_d = S_IDLE;
                end else begin
                    e = tick && (cnt != hi_q);
                    if (tick && (cnt == hi_q)) begin
`ifdef UPDOWN_SWEEP_HOLD_EN
                        state_d = S_HOLD_HI;
`else
                        state_d = S_DOWN;
`endif
                    end
                end
            end

            S_DOWN: begin
                m = 1'b0;
                if (stop) begin
                    state_d = S_IDLE;
                end else begin
                    e = tick && (cnt != lo_q);
                    if (tick && (cnt == lo_q)) begin
                        sweep_inc = 1'b1;
                        // cyc_q == 0 is continuous mode: the sweep count wraps and never matches
                        if ((cyc_q != 4'd0) && (sweep_nxt == cyc_q)) begin
                            done_d  = 1'b1;
                            state_d = S_IDLE;
                        end else begin
`ifdef UPDOWN_SWEEP_HOLD_EN
                            state_d = S_HOLD_LO;
`else
                            state_d = S_UP;
`endif
                        end
                    end
                end
            end

`ifdef UPDOWN_SWEEP_HOLD_EN
            S_HOLD_HI: begin
                m = 1'b1;
                if (stop) begin
                    state_d = S_IDLE;
                end else if (tick) begin
                    state_d = S_DOWN;
                end
            end

            S_HOLD_LO: begin
                m = 1'b0;
                if (stop) begin
                    state_d = S_IDLE;
                end else if (tick) begin
                    state_d = S_UP;
                end
            end
`endif

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            lo_q    <= 4'd0;
            hi_q    <= 4'd0;
            div_q   <= '0;
            cyc_q   <= 4'd0;
            sweep_q <= 4'd0;
        end else if (capture) begin
            lo_q    <= lo;
            hi_q    <= hi;
            div_q   <= div;
            cyc_q   <= cycles;
            sweep_q <= 4'd0;
        end else if (sweep_inc) begin
            sweep_q <= sweep_nxt;
        end
    end

    // Held at zero outside the counting states, which also clears it during LOAD.
    always_ff @(posedge clk) begin
        if (clr) begin
            presc_q <= '0;
        end else if (!counting || tick) begin
            presc_q <= '0;
        end else begin
            presc_q <= presc_q + DIV_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            done_q <= done_d;
            err_q  <= err_d;
        end
    end

endmodule
